// File: rtl/fetch_ctrl.sv
// rtl/fetch_ctrl.sv - fetch-stage sequencer: one outstanding imem fetch, decode handshake, redirects
module fetch_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  input  logic        trap,
  input  logic [31:0] trap_vec,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        if_ready,
  output logic [31:0] next_pc,
  output logic        pc_en,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc
);

  localparam logic [31:0] NOP_INSTR = 32'h00000013;

  typedef enum logic [1:0] {BOOT, REQ, WAIT, OUT} state_t;

  state_t      state, state_nxt;
  logic        pend, pend_nxt;
  logic        pend_trap, pend_trap_nxt;
  logic [31:0] pend_tgt, pend_tgt_nxt;
  logic        if_valid_nxt;
  logic        capture;
  logic        redir;
  logic [31:0] redir_tgt;
  logic [31:0] pc_plus4;

  assign imem_addr = pc;
  assign pc_plus4  = pc + 32'd4;
  assign redir     = trap | br_taken;
  assign redir_tgt = trap ? trap_vec : br_target;

  // Next-state, pending-redirect bookkeeping and PC-register load control.
  always_comb begin
    state_nxt     = state;
    pend_nxt      = pend;
    pend_trap_nxt = pend_trap;
    pend_tgt_nxt  = pend_tgt;
    if_valid_nxt  = if_valid;
    capture       = 1'b0;
    pc_en         = 1'b0;
    next_pc       = pc_plus4;
    imem_req      = 1'b0;

    // While a fetch is in flight, redirects are remembered; a trap always
    // wins, a branch may not displace a trap that is already pending.
    if (state == REQ || state == WAIT) begin
      if (trap) begin
        pend_nxt      = 1'b1;
        pend_trap_nxt = 1'b1;
        pend_tgt_nxt  = trap_vec;
      end else if (br_taken) begin
        pend_nxt = 1'b1;
        if (!pend_trap) pend_tgt_nxt = br_target;
      end
    end

    case (state)
      BOOT: state_nxt = REQ;
      REQ: begin
        imem_req = 1'b1;
        if (imem_ready) state_nxt = WAIT;
      end
      WAIT: begin
        if (imem_rvalid) begin
          pc_en = 1'b1;
          if (pend_nxt) begin
            // Wrong-path response: drop it and steer the PC to the redirect.
            next_pc       = pend_tgt_nxt;
            pend_nxt      = 1'b0;
            pend_trap_nxt = 1'b0;
            state_nxt     = REQ;
          end else begin
            capture      = 1'b1;
            if_valid_nxt = 1'b1;
            state_nxt    = OUT;
          end
        end
      end
      OUT: begin
        if (redir) begin
          if_valid_nxt = 1'b0;
          pc_en        = 1'b1;
          next_pc      = redir_tgt;
          state_nxt    = REQ;
        end else if (if_ready) begin
          if_valid_nxt = 1'b0;
          state_nxt    = REQ;
        end
      end
      default: state_nxt = BOOT;
    endcase

    // Reset aborts everything, including a same-cycle PC load.
    if (rst) begin
      pc_en    = 1'b0;
      next_pc  = pc_plus4;
      imem_req = 1'b0;
    end
  end

  // State, pending-redirect and decode-output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= BOOT;
      pend      <= 1'b0;
      pend_trap <= 1'b0;
      pend_tgt  <= 32'd0;
      if_valid  <= 1'b0;
      if_instr  <= NOP_INSTR;
      if_pc     <= 32'd0;
    end else begin
      state     <= state_nxt;
      pend      <= pend_nxt;
      pend_trap <= pend_trap_nxt;
      pend_tgt  <= pend_tgt_nxt;
      if_valid  <= if_valid_nxt;
      if (capture) begin
        if_instr <= imem_rdata;
        if_pc    <= pc;
      end
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb/tb_fetch_ctrl.sv - directed self-checking bench for fetch_ctrl
module tb_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc;
  logic        br_taken;
  logic [31:0] br_target;
  logic        trap;
  logic [31:0] trap_vec;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        if_ready;
  logic [31:0] next_pc;
  logic        pc_en;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;

  int n_cmp = 0;
  int n_err = 0;
  int mem_lat;
  logic        mem_busy;
  int          mem_cnt;
  logic [31:0] mem_addr;

  fetch_ctrl dut (
    .clk(clk), .rst(rst), .pc(pc),
    .br_taken(br_taken), .br_target(br_target),
    .trap(trap), .trap_vec(trap_vec),
    .imem_ready(imem_ready), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .if_ready(if_ready),
    .next_pc(next_pc), .pc_en(pc_en),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] word(input logic [31:0] a);
    return 32'h00500093 + (a << 8);
  endfunction

  // PC register model.
  always @(posedge clk) begin
    if (rst) pc <= 32'd0;
    else if (pc_en) pc <= next_pc;
  end

  // Instruction memory: response mem_lat cycles after acceptance.
  always @(posedge clk) begin
    if (rst) begin
      mem_busy    <= 1'b0;
      mem_cnt     <= 0;
      mem_addr    <= 32'd0;
      imem_rvalid <= 1'b0;
      imem_rdata  <= 32'd0;
    end else begin
      imem_rvalid <= 1'b0;
      if (mem_busy) begin
        if (mem_cnt == 1) begin
          imem_rvalid <= 1'b1;
          imem_rdata  <= word(mem_addr);
          mem_busy    <= 1'b0;
        end else begin
          mem_cnt <= mem_cnt - 1;
        end
      end else if (imem_req && imem_ready) begin
        if (mem_lat <= 1) begin
          imem_rvalid <= 1'b1;
          imem_rdata  <= word(imem_addr);
        end else begin
          mem_busy <= 1'b1;
          mem_cnt  <= mem_lat - 1;
          mem_addr <= imem_addr;
        end
      end
    end
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic settle;
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; br_taken = 1'b0; br_target = 32'd0; trap = 1'b0; trap_vec = 32'd0;
    imem_ready = 1'b1; if_ready = 1'b1; mem_lat = 1;
    step; step;
    rst = 1'b0;
    settle;
    // Reset state (BOOT)
    chk("rst_req", imem_req, 0);
    chk("rst_pc_en", pc_en, 0);
    chk("rst_if_valid", if_valid, 0);
    chk("rst_if_instr", if_instr, 32'h00000013);
    chk("rst_if_pc", if_pc, 0);
    step;
    // First fetch
    chk("first_req", imem_req, 1);
    chk("first_addr", imem_addr, 0);
    step;
    chk("first_wait_pc_en", pc_en, 1);
    chk("first_next_pc", next_pc, 4);
    chk("first_wait_valid", if_valid, 0);
    step;
    chk("first_valid", if_valid, 1);
    chk("first_instr", if_instr, 32'h00500093);
    chk("first_if_pc", if_pc, 0);
    chk("first_out_pc_en", pc_en, 0);

    // Sequential stream, one instruction per 3 cycles
    for (int k = 1; k <= 4; k++) begin
      step;
      chk("seq_req", imem_req, 1);
      chk("seq_addr", imem_addr, 32'(4 * k));
      chk("seq_req_valid", if_valid, 0);
      step;
      chk("seq_next_pc", next_pc, 32'(4 * k + 4));
      chk("seq_pc_en", pc_en, 1);
      if (k == 4) if_ready = 1'b0;
      step;
      chk("seq_valid", if_valid, 1);
      chk("seq_if_pc", if_pc, 32'(4 * k));
      chk("seq_instr", if_instr, word(32'(4 * k)));
    end

    // Decode stall: output held, no new request
    for (int i = 0; i < 5; i++) begin
      step;
      chk("stall_valid", if_valid, 1);
      chk("stall_instr", if_instr, word(32'd16));
      chk("stall_req", imem_req, 0);
    end
    if_ready = 1'b1;
    mem_lat = 3;
    step;
    chk("post_stall_addr", imem_addr, 32'd20);

    // Branch during WAIT
    step;
    br_taken = 1'b1; br_target = 32'h100;
    settle;
    chk("bw_pc_en_w1", pc_en, 0);
    step;
    br_taken = 1'b0;
    settle;
    chk("bw_pc_en_w2", pc_en, 0);
    step;
    chk("bw_pc_en_rv", pc_en, 1);
    chk("bw_next_pc", next_pc, 32'h100);
    mem_lat = 1;
    step;
    chk("bw_no_valid", if_valid, 0);
    chk("bw_addr", imem_addr, 32'h100);
    chk("bw_req", imem_req, 1);
    step;
    chk("bw_next_pc2", next_pc, 32'h104);
    if_ready = 1'b0;
    step;
    chk("bo_valid", if_valid, 1);
    chk("bo_if_pc", if_pc, 32'h100);

    // Branch in OUT with decode stalled
    br_taken = 1'b1; br_target = 32'h40;
    settle;
    chk("bo_pc_en", pc_en, 1);
    chk("bo_next_pc", next_pc, 32'h40);
    step;
    br_taken = 1'b0;
    if_ready = 1'b1;
    mem_lat = 3;
    settle;
    chk("bo_flush", if_valid, 0);
    chk("bo_addr", imem_addr, 32'h40);

    // Trap then branch while waiting: trap target kept
    step;
    trap = 1'b1; trap_vec = 32'h80;
    settle;
    step;
    trap = 1'b0; br_taken = 1'b1; br_target = 32'h200;
    settle;
    chk("tp_pc_en_w2", pc_en, 0);
    step;
    br_taken = 1'b0;
    settle;
    chk("tp_pc_en", pc_en, 1);
    chk("tp_next_pc", next_pc, 32'h80);
    mem_lat = 1;
    step;
    chk("tp_addr", imem_addr, 32'h80);
    chk("tp_no_valid", if_valid, 0);
    step;
    if_ready = 1'b0;
    step;
    chk("tp_out_valid", if_valid, 1);
    chk("tp_out_if_pc", if_pc, 32'h80);

    // Simultaneous trap + branch in OUT
    trap = 1'b1; trap_vec = 32'h80; br_taken = 1'b1; br_target = 32'h300;
    settle;
    chk("ts_pc_en", pc_en, 1);
    chk("ts_next_pc", next_pc, 32'h80);
    step;
    trap = 1'b0; br_taken = 1'b0; if_ready = 1'b1;
    settle;
    chk("ts_flush", if_valid, 0);
    chk("ts_addr", imem_addr, 32'h80);

    // Branch arriving with the response itself
    step;
    br_taken = 1'b1; br_target = 32'h180;
    settle;
    chk("bs_pc_en", pc_en, 1);
    chk("bs_next_pc", next_pc, 32'h180);
    step;
    br_taken = 1'b0;
    mem_lat = 3;
    settle;
    chk("bs_no_valid", if_valid, 0);
    chk("bs_addr", imem_addr, 32'h180);

    // Mid-operation reset with a pending redirect
    step;
    br_taken = 1'b1; br_target = 32'h500;
    settle;
    step;
    br_taken = 1'b0; rst = 1'b1;
    settle;
    chk("mr_no_pc_en", pc_en, 0);
    chk("mr_no_req", imem_req, 0);
    step;
    rst = 1'b0; mem_lat = 1;
    settle;
    chk("mr_valid", if_valid, 0);
    chk("mr_boot_req", imem_req, 0);
    chk("mr_boot_pc_en", pc_en, 0);
    step;
    chk("mr_req", imem_req, 1);
    chk("mr_addr", imem_addr, 0);
    chk("mr_req_pc_en", pc_en, 0);
    step;
    chk("mr_wait_pc_en", pc_en, 1);
    chk("mr_next_pc", next_pc, 4);
    step;
    chk("mr_out_valid", if_valid, 1);
    chk("mr_out_if_pc", if_pc, 0);
    chk("mr_out_instr", if_instr, 32'h00500093);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
